// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: decode-side issue bundle and the hazard unit's stall/forward responses.
interface pipe_hazard_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3
);
    localparam int SELW = $clog2(DEPTH + 1);
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rs1;
    logic [REG_AW-1:0] issue_rs2;
    logic              issue_rs1_used;
    logic              issue_rs2_used;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_rd_wr;
    logic              issue_is_load;
    logic              flush;
    logic              issue_ready;
    logic              stall;
    logic [SELW-1:0]   rs1_fwd_sel;
    logic [SELW-1:0]   rs2_fwd_sel;
    logic [31:0]       stall_cnt;
    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_wr, issue_is_load, flush,
        input  issue_ready, stall, rs1_fwd_sel, rs2_fwd_sel, stall_cnt
    );
    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
               issue_rd, issue_rd_wr, issue_is_load, flush,
        output issue_ready, stall, rs1_fwd_sel, rs2_fwd_sel, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: RAW hazard detection with stage forwarding over a DEPTH-stage scoreboard.
// Define HAZARD_FWD_EN to forward; otherwise every in-flight producer short of writeback stalls.
module pipe_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rstn,
    pipe_hazard_if.slave bus
);
`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    logic [DEPTH:1]    v;
    logic [DEPTH:1]    ld;
    logic [REG_AW-1:0] rd [1:DEPTH];
    logic [SELW-1:0]   sel1, sel2;
    logic              hz1, hz2, stall, ready;
    logic [31:0]       cnt;
    // Load hazards are a subset of the no-forwarding hazard window since LOAD_STAGE <= DEPTH.
    function automatic logic haz(input int k, input logic l);
        return FWD_EN ? (l && k < LOAD_STAGE) : (k < DEPTH || (l && k < LOAD_STAGE));
    endfunction
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        hz1  = 1'b0;
        hz2  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (v[k] && rd[k] != '0 && bus.issue_valid) begin
                if (bus.issue_rs1_used && rd[k] == bus.issue_rs1) begin
                    sel1 = SELW'(k);
                    hz1  = haz(k, ld[k]);
                end
                if (bus.issue_rs2_used && rd[k] == bus.issue_rs2) begin
                    sel2 = SELW'(k);
                    hz2  = haz(k, ld[k]);
                end
            end
        end
    end
    assign stall           = (hz1 | hz2) & ~bus.flush;
    assign ready           = bus.issue_valid & ~stall & ~bus.flush;
    assign bus.stall       = stall;
    assign bus.issue_ready = ready;
    assign bus.rs1_fwd_sel = (FWD_EN && !stall && !bus.flush) ? sel1 : '0;
    assign bus.rs2_fwd_sel = (FWD_EN && !stall && !bus.flush) ? sel2 : '0;
    assign bus.stall_cnt   = cnt;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v   <= '0;
            cnt <= '0;
        end else begin
            v <= {v[DEPTH-1:1], ready & bus.issue_rd_wr};
            if (stall && cnt != '1)
                cnt <= cnt + 32'd1;
        end
    end
    always_ff @(posedge clk) begin
        ld    <= {ld[DEPTH-1:1], bus.issue_is_load};
        rd[1] <= bus.issue_rd;
        for (int k = 2; k <= DEPTH; k++)
            rd[k] <= rd[k-1];
    end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: table-driven scoreboard bench for pipe_hazard_unit (DEPTH=3, LOAD_STAGE=2).
module tb_pipe_hazard_unit;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct {
        logic       iv, u1, u2, wr, ld, fl;
        logic [4:0] r1, r2, rd;
        logic       st;
        logic [1:0] s1, s2;
    } vec_t;
    typedef struct {
        logic        st, rdy;
        logic [1:0]  s1, s2;
        logic [31:0] cnt;
    } exp_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    exp_t sb[$];
    logic [31:0] exp_cnt = '0;
    always #5 clk = ~clk;
    pipe_hazard_if #(.REG_AW(5), .DEPTH(3)) bus ();
    pipe_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_STAGE(2)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );
    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask
    // Expected stall/forward given for the forwarding build (stf, s1f, s2f) and the no-forward build (stn).
    task automatic add(input logic iv, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] rd, input logic wr, input logic ld,
                       input logic fl, input logic stf, input logic [1:0] s1f, input logic [1:0] s2f,
                       input logic stn);
        vec_t t;
        t.iv = iv; t.r1 = r1; t.u1 = u1; t.r2 = r2; t.u2 = u2;
        t.rd = rd; t.wr = wr; t.ld = ld; t.fl = fl;
        t.st = FWD ? stf : stn;
        t.s1 = FWD ? s1f : 2'd0;
        t.s2 = FWD ? s2f : 2'd0;
        vecs.push_back(t);
    endtask
    task automatic idle();
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic drive(input vec_t t);
        bus.issue_valid = t.iv; bus.issue_rs1 = t.r1; bus.issue_rs1_used = t.u1;
        bus.issue_rs2 = t.r2; bus.issue_rs2_used = t.u2; bus.issue_rd = t.rd;
        bus.issue_rd_wr = t.wr; bus.issue_is_load = t.ld; bus.flush = t.fl;
    endtask
    initial begin
        exp_t e;
        vec_t t;
        idle();
        add(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        idle();
        add(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 2, 1);
        add(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 3, 0);
        idle();
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        add(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        add(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        idle();
        add(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        add(1, 9, 1, 0, 0, 10, 1, 0, 1, 0, 0, 0, 0);
        add(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        add(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        add(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        idle();
        add(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0);
        add(1, 3, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        add(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 3, 2, 1);
        add(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 3, 0);
        idle();
        add(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        add(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        idle();
        add(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0);
        add(1, 12, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        t = vecs[1];
        t.r1 = 5; t.u1 = 1;
        drive(t);
        #2;
        chk("reset_stall", bus.stall, 0);
        chk("reset_ready", bus.issue_ready, 1);
        chk("reset_sel1", bus.rs1_fwd_sel, 0);
        chk("reset_cnt", bus.stall_cnt, 0);
        drive(vecs[0]);
        @(negedge clk);
        rstn = 1'b1;
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            e.st  = vecs[i].st;
            e.rdy = vecs[i].iv & ~vecs[i].st & ~vecs[i].fl;
            e.s1  = vecs[i].s1;
            e.s2  = vecs[i].s2;
            e.cnt = exp_cnt;
            if (vecs[i].st) exp_cnt++;
            sb.push_back(e);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_stall", i), bus.stall, e.st);
                chk($sformatf("v%0d_ready", i), bus.issue_ready, e.rdy);
                chk($sformatf("v%0d_sel1", i), bus.rs1_fwd_sel, e.s1);
                chk($sformatf("v%0d_sel2", i), bus.rs2_fwd_sel, e.s2);
                chk($sformatf("v%0d_cnt", i), bus.stall_cnt, e.cnt);
            end
        end
        @(posedge clk);
        #1;
        t = vecs[0];
        t.iv = 1; t.rd = 5; t.wr = 1; t.ld = 1;
        drive(t);
        @(posedge clk);
        #1;
        t = vecs[0];
        t.iv = 1; t.r1 = 5; t.u1 = 1;
        drive(t);
        #2;
        chk("pre_rst_stall", bus.stall, 1);
        chk("pre_rst_cnt", bus.stall_cnt, exp_cnt);
        rstn = 1'b0;
        #1;
        chk("async_rst_stall", bus.stall, 0);
        chk("async_rst_ready", bus.issue_ready, 1);
        chk("async_rst_cnt", bus.stall_cnt, 0);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", bus.stall, 0);
        chk("post_rst_sel1", bus.rs1_fwd_sel, 0);
        chk("post_rst_cnt", bus.stall_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter REG_AW, 5: register-address width.
REQ-002 Parameter DEPTH, 3: number of tracked post-decode stages; legal range 2..6; stage 1 = execute, stage DEPTH = writeback.
REQ-003 Parameter LOAD_STAGE, 2: first stage at which load data is forwardable; legal range 1..DEPTH.
REQ-004 Derived SELW = $clog2(DEPTH+1).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset.
REQ-007 issue_valid  in  1  decode presents an instruction this cycle.
REQ-008 issue_rs1 / issue_rs2  in  REG_AW each  source register addresses.
REQ-009 issue_rs1_used / issue_rs2_used  in  1 each  source actually read.
REQ-010 issue_rd  in  REG_AW  destination address.
REQ-011 issue_rd_wr  in  1  instruction writes rd.
REQ-012 issue_is_load  in  1  instruction is a load.
REQ-013 flush  in  1  taken branch/jump resolved in execute; kills the issuing instruction.
REQ-014 issue_ready  out  1  decode instruction accepted this cycle.
REQ-015 stall  out  1  hold PC and decode this cycle.
REQ-016 rs1_fwd_sel / rs2_fwd_sel  out  SELW each  0 = register file, k = forward from stage k.
REQ-017 stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-018 State is a DEPTH-entry shift register; each entry holds valid, rd, is_load; every entry advances one stage per cycle unconditionally; stage DEPTH retires.
REQ-019 Entry "matches" source rs when: valid, rd == rs, rd != 0, rs_used = 1, issue_valid = 1.
REQ-020 The youngest match (smallest k) defines the result for that source; older matches are ignored.
REQ-021 Youngest match is a load at k < LOAD_STAGE: stall = 1 for that source; otherwise fwd_sel = k; no match: fwd_sel = 0.
REQ-022 stall = OR over both sources, forced 0 when flush = 1; issue_ready = issue_valid & ~stall & ~flush.
REQ-023 fwd_sel outputs are 0 whenever stall = 1 or flush = 1.
REQ-024 Stage 1 loads {1, issue_rd, issue_is_load} when issue_ready = 1 and issue_rd_wr = 1; otherwise it loads a bubble (valid = 0).
REQ-025 Outputs stall, issue_ready and fwd_sel are combinational from state and issue inputs; there is no added latency.
REQ-026 stall_cnt increments by 1 on each cycle where stall = 1 and holds at 32'hFFFF_FFFF.
REQ-027 flush with issue_valid = 0 inserts a bubble and has no other effect; entries already in stages 1..DEPTH are never killed.

Reset
REQ-028 rstn low clears all entry valid bits and stall_cnt to 0 immediately, independent of clk.
REQ-029 While in reset and after release with the pipeline empty: stall = 0, fwd_sel = 0, issue_ready = issue_valid.
REQ-030 Reset asserted during a stall drops stall within the same cycle.

Configuration
REQ-031 Macro HAZARD_FWD_EN defined: forwarding behaviour per REQ-020..REQ-023.
REQ-032 Macro HAZARD_FWD_EN undefined: fwd_sel is tied to 0; any match at k < DEPTH stalls, regardless of is_load; a match at k = DEPTH does not stall (register file is write-through).

Verification (DEPTH = 3, LOAD_STAGE = 2, macro defined unless noted)
REQ-033 Issue add x5; next cycle issue rs1 = x5 -> stall = 0, rs1_fwd_sel = 1, issue_ready = 1.
REQ-034 Issue lw x6; next cycle issue rs2 = x6 -> stall = 1 for one cycle, then rs2_fwd_sel = 2, stall_cnt = 1.
REQ-035 Issue write to x0; next cycle read x0 -> fwd_sel = 0, stall = 0.
REQ-036 Writes to x7 on two consecutive cycles, then read x7 -> rs1_fwd_sel = 1 (youngest wins).
REQ-037 flush = 1 with a matching issue -> stall = 0, issue_ready = 0; next cycle stage 1 invalid; stall_cnt unchanged.
REQ-038 Macro undefined: add x5, then read x5 -> stall = 1 for exactly 2 cycles, then issue_ready = 1 with fwd_sel = 0, stall_cnt = 2.
